// File: rtl/uart_tx_if.sv
// Handshake and line signals between a byte producer and the UART transmitter.
interface uart_tx_if;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       tx_out;
  logic       tx_busy;
  logic       tx_done;

  modport master (
    output tx_valid, tx_data,
    input  tx_ready, tx_out, tx_busy, tx_done
  );

  modport slave (
    input  tx_valid, tx_data,
    output tx_ready, tx_out, tx_busy, tx_done
  );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB-first, optional parity, 1 or 2 stop bits.
// Bit timing is derived from the system clock by an integer divisor.
module uart_tx #(
  parameter int CLOCK     = 100000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic     clk_i,
  input  logic     rst_i,
  uart_tx_if.slave tx_if
);

  localparam int DIVISOR = CLOCK / BAUD_RATE;
  localparam int CNT_W   = (DIVISOR < 2) ? 1 : $clog2(DIVISOR);

  if (DIVISOR < 2) begin : g_div_check
    $error("uart_tx: CLOCK / BAUD_RATE must be at least 2");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_parity_check
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_stop_check
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             parity_q, parity_d;
  logic             tx_out_q, tx_out_d;
  logic             done_q, done_d;
  logic             bit_end;

  assign bit_end = (cnt_q == CNT_W'(DIVISOR - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_out_q  <= 1'b1;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_out_q  <= tx_out_d;
      done_q    <= done_d;
    end
  end

  // The bit counter wraps at every bit boundary; bit_idx_q is reused to count stop bits.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    parity_d  = parity_q;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (tx_if.tx_valid && tx_if.tx_ready) begin
          state_d   = S_START;
          shift_d   = tx_if.tx_data;
          parity_d  = ^tx_if.tx_data;
          cnt_d     = '0;
          bit_idx_d = '0;
        end
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            bit_idx_d = '0;
            state_d   = (PARITY != 0) ? S_PAR : S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      S_PAR: begin
        if (bit_end) state_d = S_STOP;
      end
      S_STOP: begin
        if (bit_end) begin
          if (bit_idx_q == 3'(STOP_BITS - 1)) begin
            bit_idx_d = '0;
            state_d   = S_IDLE;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Line level is decoded from the next state so the registered output lines up with it.
  always_comb begin
    tx_out_d = 1'b1;
    case (state_d)
      S_START: tx_out_d = 1'b0;
      S_DATA:  tx_out_d = shift_d[0];
      S_PAR:   tx_out_d = (PARITY == 2) ? ~parity_d : parity_d;
      default: tx_out_d = 1'b1;
    endcase
    done_d = (state_q == S_STOP) && (state_d == S_IDLE);
  end

  assign tx_if.tx_ready = (state_q == S_IDLE);
  assign tx_if.tx_busy  = (state_q != S_IDLE);
  assign tx_if.tx_out   = tx_out_q;
  assign tx_if.tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: four instances cover no/even/odd parity and two stop bits,
// a select variable routes stimulus to one instance and its outputs to the checks.
module tb_uart_tx;

  localparam int DIV = 16;

  logic       clk;
  logic       rst;
  logic       valid;
  logic [7:0] data;
  int         sel;
  int         checks;
  int         passed;

  logic obsOut, obsBusy, obsReady, obsDone;

  uart_tx_if if0 ();
  uart_tx_if if1 ();
  uart_tx_if if2 ();
  uart_tx_if if3 ();

  assign if0.tx_valid = valid && (sel == 0);
  assign if1.tx_valid = valid && (sel == 1);
  assign if2.tx_valid = valid && (sel == 2);
  assign if3.tx_valid = valid && (sel == 3);
  assign if0.tx_data  = data;
  assign if1.tx_data  = data;
  assign if2.tx_data  = data;
  assign if3.tx_data  = data;

  uart_tx #(.CLOCK(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk_i(clk), .rst_i(rst), .tx_if(if0));
  uart_tx #(.CLOCK(160), .BAUD_RATE(10), .PARITY(1), .STOP_BITS(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .tx_if(if1));
  uart_tx #(.CLOCK(160), .BAUD_RATE(10), .PARITY(2), .STOP_BITS(1)) dut2 (
    .clk_i(clk), .rst_i(rst), .tx_if(if2));
  uart_tx #(.CLOCK(160), .BAUD_RATE(10), .PARITY(0), .STOP_BITS(2)) dut3 (
    .clk_i(clk), .rst_i(rst), .tx_if(if3));

  always #5 clk = ~clk;

  always_comb begin
    obsOut = if0.tx_out; obsBusy = if0.tx_busy; obsReady = if0.tx_ready; obsDone = if0.tx_done;
    case (sel)
      1: begin obsOut = if1.tx_out; obsBusy = if1.tx_busy; obsReady = if1.tx_ready; obsDone = if1.tx_done; end
      2: begin obsOut = if2.tx_out; obsBusy = if2.tx_busy; obsReady = if2.tx_ready; obsDone = if2.tx_done; end
      3: begin obsOut = if3.tx_out; obsBusy = if3.tx_busy; obsReady = if3.tx_ready; obsDone = if3.tx_done; end
      default: ;
    endcase
  end

  function automatic int parityMode(input int s);
    return (s == 1) ? 1 : (s == 2) ? 2 : 0;
  endfunction

  function automatic int stopBits(input int s);
    return (s == 3) ? 2 : 1;
  endfunction

  function automatic int frameBits(input int s);
    return 9 + ((parityMode(s) != 0) ? 1 : 0) + stopBits(s);
  endfunction

  // Expected line level for frame bit k (k = 0 is the start bit).
  function automatic logic expBit(input int s, input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (k == 9 && parityMode(s) == 1) return ^b;
    if (k == 9 && parityMode(s) == 2) return ~(^b);
    return 1'b1;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) begin
      passed++;
    end else begin
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Offers b (unless already offered), follows the frame through its tx_done cycle and
  // leaves the bench at the negedge of that cycle with valid = holdNext, data = nextByte.
  task automatic applyStimulus(input logic [7:0] b, input logic offered, input logic holdNext,
                               input logic [7:0] nextByte, input int pokeCycle);
    int         total;
    int         k;
    logic       sawDone;
    logic [7:0] rxByte;
    total   = frameBits(sel) * DIV;
    sawDone = 1'b0;
    rxByte  = 8'h00;
    if (!offered) begin
      @(negedge clk);
      valid = 1'b1;
      data  = b;
    end
    @(posedge clk);
    #1;
    valid = holdNext;
    data  = holdNext ? nextByte : ~b;
    for (int c = 1; c <= total + 1; c++) begin
      @(negedge clk);
      if (c <= total) begin
        k = (c - 1) / DIV;
        if ((c - 1) % DIV == 0 || c % DIV == 0) begin
          checkOutput($sformatf("sel%0d byte%0h c%0d out", sel, b, c), {7'b0, obsOut},
                      {7'b0, expBit(sel, b, k)});
          checkOutput($sformatf("sel%0d byte%0h c%0d busy", sel, b, c), {7'b0, obsBusy}, 8'd1);
        end
        if ((c - 1) % DIV == DIV / 2 && k >= 1 && k <= 8) rxByte[k-1] = obsOut;
        if (obsDone) sawDone = 1'b1;
      end else begin
        checkOutput($sformatf("sel%0d byte%0h done", sel, b), {7'b0, obsDone}, 8'd1);
        checkOutput($sformatf("sel%0d byte%0h ready", sel, b), {7'b0, obsReady}, 8'd1);
        checkOutput($sformatf("sel%0d byte%0h idle busy", sel, b), {7'b0, obsBusy}, 8'd0);
        checkOutput($sformatf("sel%0d byte%0h idle out", sel, b), {7'b0, obsOut}, 8'd1);
      end
      if (c == pokeCycle) begin
        valid = 1'b1;
        data  = 8'hFF;
      end else if (c == pokeCycle + 1) begin
        valid = holdNext;
        data  = holdNext ? nextByte : ~b;
      end
    end
    checkOutput($sformatf("sel%0d byte%0h early done", sel, b), {7'b0, sawDone}, 8'd0);
    checkOutput($sformatf("sel%0d byte%0h rx sample", sel, b), rxByte, b);
  endtask

  initial begin
    logic bad;
    clk    = 1'b0;
    rst    = 1'b1;
    valid  = 1'b0;
    data   = 8'h00;
    sel    = 0;
    checks = 0;
    passed = 0;

    repeat (3) @(negedge clk);
    for (int s = 0; s < 4; s++) begin
      sel = s;
      #1;
      checkOutput($sformatf("reset sel%0d out", s), {7'b0, obsOut}, 8'd1);
      checkOutput($sformatf("reset sel%0d busy", s), {7'b0, obsBusy}, 8'd0);
      checkOutput($sformatf("reset sel%0d ready", s), {7'b0, obsReady}, 8'd1);
      checkOutput($sformatf("reset sel%0d done", s), {7'b0, obsDone}, 8'd0);
    end
    sel = 0;
    rst = 1'b0;

    // Basic frame, no parity, one stop bit.
    applyStimulus(8'h55, 1'b0, 1'b0, 8'h00, 0);

    // Reset wins over a simultaneous offer.
    @(negedge clk);
    rst   = 1'b1;
    valid = 1'b1;
    data  = 8'h55;
    @(negedge clk);
    checkOutput("rst priority busy", {7'b0, obsBusy}, 8'd0);
    checkOutput("rst priority out", {7'b0, obsOut}, 8'd1);
    rst   = 1'b0;
    valid = 1'b0;

    // Even then odd parity on a byte with four ones.
    sel = 1;
    applyStimulus(8'hA3, 1'b0, 1'b0, 8'h00, 0);
    sel = 2;
    applyStimulus(8'hA3, 1'b0, 1'b0, 8'h00, 0);

    // Back-to-back with two stop bits; second start bit follows the tx_done cycle directly.
    sel = 3;
    applyStimulus(8'h00, 1'b0, 1'b1, 8'hFF, 0);
    applyStimulus(8'hFF, 1'b1, 1'b0, 8'h00, 0);

    // Reset in the middle of a frame.
    sel = 0;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h0F;
    @(posedge clk);
    #1;
    valid = 1'b0;
    for (int c = 1; c <= 50; c++) @(negedge clk);
    checkOutput("midreset c50 out", {7'b0, obsOut}, {7'b0, expBit(0, 8'h0F, 3)});
    rst = 1'b1;
    @(negedge clk);
    checkOutput("midreset out", {7'b0, obsOut}, 8'd1);
    checkOutput("midreset busy", {7'b0, obsBusy}, 8'd0);
    checkOutput("midreset ready", {7'b0, obsReady}, 8'd1);
    checkOutput("midreset done", {7'b0, obsDone}, 8'd0);
    rst = 1'b0;
    bad = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (obsDone || obsBusy || !obsOut) bad = 1'b1;
    end
    checkOutput("midreset quiet", {7'b0, bad}, 8'd0);
    applyStimulus(8'hC6, 1'b0, 1'b0, 8'h00, 0);

    // A valid pulse during DATA must be ignored and not queued.
    applyStimulus(8'h3C, 1'b0, 1'b0, 8'h00, 40);
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (obsBusy || !obsOut) bad = 1'b1;
    end
    checkOutput("ignored valid no frame", {7'b0, bad}, 8'd0);

    // Extra byte patterns through the plain instance.
    applyStimulus(8'h7E, 1'b0, 1'b0, 8'h00, 0);
    applyStimulus(8'h80, 1'b0, 1'b0, 8'h00, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
